// File: rtl/gemm_fwec_stream_scheduler.sv
// Job sequencer for the fixed-weights GEMM core.
// Loads an SA_SIZE x SA_SIZE weight tile row by row, then admits activation
// vectors into the free-running core only while a result slot is guaranteed
// (credit = results in flight + results waiting in the FIFO), and replays the
// core outputs through a first-word fall-through result FIFO.
//
// Handshake rule for every stream (w, act, res): a transfer happens on the
// rising edge where valid && ready are both high; the source holds its data
// stable while valid is high and ready is low, and ready never depends on a
// transfer in the same cycle of the same stream.
module gemm_fwec_stream_scheduler #(
  parameter int SA_SIZE                = 8,
  parameter int WEIGHT_ACTIVATION_SIZE = 8,
  parameter int OUT_DEPTH              = 16,
  parameter int CNT_W                  = 16
) (
  input  logic                                       clk,
  input  logic                                       resetn,
  input  logic                                       start,
  input  logic [CNT_W-1:0]                           num_vectors,
  input  logic                                       w_valid,
  output logic                                       w_ready,
  input  logic [SA_SIZE*WEIGHT_ACTIVATION_SIZE-1:0]  w_row,
  input  logic                                       act_valid,
  output logic                                       act_ready,
  input  logic [SA_SIZE*WEIGHT_ACTIVATION_SIZE-1:0]  act_data,
  output logic                                       sa_w_we,
  output logic [$clog2(SA_SIZE)-1:0]                 sa_w_idx,
  output logic [SA_SIZE*WEIGHT_ACTIVATION_SIZE-1:0]  sa_w_row,
  output logic [SA_SIZE*WEIGHT_ACTIVATION_SIZE-1:0]  sa_act,
  input  logic [SA_SIZE*WEIGHT_ACTIVATION_SIZE-1:0]  sa_out,
  output logic                                       res_valid,
  input  logic                                       res_ready,
  output logic [SA_SIZE*WEIGHT_ACTIVATION_SIZE-1:0]  res_data,
  output logic                                       res_last,
  output logic                                       busy,
  output logic                                       done,
  output logic [1:0]                                 dbg_state
);

  localparam int VW     = SA_SIZE * WEIGHT_ACTIVATION_SIZE;
  localparam int LAT    = 2 * SA_SIZE;
  localparam int IDX_W  = $clog2(SA_SIZE);
  localparam int WCNT_W = $clog2(SA_SIZE + 1);
  localparam int PTR_W  = $clog2(OUT_DEPTH);
  localparam int FCNT_W = $clog2(OUT_DEPTH + 1);
  localparam int CRED_W = $clog2(LAT + OUT_DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD_W = 2'd1,
    S_STREAM = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic                done_nxt;
  logic [CNT_W-1:0]    num_reg;
  logic [CNT_W-1:0]    acc_cnt;
  logic [CNT_W-1:0]    res_cnt;
  logic [WCNT_W-1:0]   w_cnt;
  logic [LAT-1:0]      tag;
  logic [VW-1:0]       fifo_mem [OUT_DEPTH];
  logic [PTR_W-1:0]    wptr, rptr;
  logic [FCNT_W-1:0]   fifo_cnt;
  logic [CRED_W-1:0]   credit_used;
  logic                w_fire, act_fire, push, pop;
  logic                last_row, last_act, drained;

  // Credits in use: every tag bit is a result that will land in the FIFO.
  always_comb begin
    credit_used = CRED_W'(fifo_cnt);
    for (int i = 0; i < LAT; i++) begin
      credit_used = credit_used + CRED_W'(tag[i]);
    end
  end

  assign w_ready   = (state == S_LOAD_W) && (tag == '0);
  assign w_fire    = w_valid && w_ready;
  assign last_row  = w_fire && (w_cnt == WCNT_W'(SA_SIZE - 1));

  assign act_ready = (state == S_STREAM) && (acc_cnt < num_reg) &&
                     (credit_used < CRED_W'(OUT_DEPTH));
  assign act_fire  = act_valid && act_ready;
  assign last_act  = act_fire && (acc_cnt == num_reg - 1'b1);
  // The core never stalls, so bubble cycles must present a zero vector.
  assign sa_act    = act_fire ? act_data : '0;

  assign push      = tag[LAT-1];
  assign res_valid = (fifo_cnt != '0);
  assign pop       = res_valid && res_ready;
  assign res_data  = fifo_mem[rptr];
  assign res_last  = res_valid && (res_cnt == num_reg - 1'b1);
  assign drained   = (tag == '0) && (fifo_cnt == '0);

  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

  // Next-state logic and the job-complete pulse request.
  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_LOAD_W;
      end
      S_LOAD_W: begin
        if (last_row) begin
          if (num_reg == '0) begin
            state_nxt = S_IDLE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = S_STREAM;
          end
        end
      end
      S_STREAM: begin
        if (last_act) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (drained) begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register and registered done pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
    end
  end

  // Job counters: vector count latched on start, weight rows, accepted
  // activations and popped results.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      num_reg <= '0;
      w_cnt   <= '0;
      acc_cnt <= '0;
      res_cnt <= '0;
    end else if (state == S_IDLE && start) begin
      num_reg <= num_vectors;
      w_cnt   <= '0;
      acc_cnt <= '0;
      res_cnt <= '0;
    end else begin
      if (w_fire)   w_cnt   <= w_cnt + 1'b1;
      if (act_fire) acc_cnt <= acc_cnt + 1'b1;
      if (pop)      res_cnt <= res_cnt + 1'b1;
    end
  end

  // Registered weight write port into the core.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sa_w_we  <= 1'b0;
      sa_w_idx <= '0;
      sa_w_row <= '0;
    end else begin
      sa_w_we <= w_fire;
      if (w_fire) begin
        sa_w_idx <= w_cnt[IDX_W-1:0];
        sa_w_row <= w_row;
      end
    end
  end

  // Tag pipe tracks which core cycles carry a real vector.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) tag <= '0;
    else         tag <= {tag[LAT-2:0], act_fire};
  end

  // Result FIFO pointers and occupancy; overflow cannot happen under the
  // credit rule, so it is flagged as a design error.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr     <= '0;
      rptr     <= '0;
      fifo_cnt <= '0;
    end else begin
      assert (!(push && !pop && fifo_cnt == FCNT_W'(OUT_DEPTH)));
      if (push) wptr <= (wptr == PTR_W'(OUT_DEPTH - 1)) ? '0 : wptr + 1'b1;
      if (pop)  rptr <= (rptr == PTR_W'(OUT_DEPTH - 1)) ? '0 : rptr + 1'b1;
      if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (pop && !push) fifo_cnt <= fifo_cnt - 1'b1;
    end
  end

  // Result FIFO storage; contents are meaningless while the count is zero.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wptr] <= sa_out;
  end

endmodule

// File: tb/tb_gemm_fwec_stream_scheduler.sv
// Bench for gemm_fwec_stream_scheduler with a 2x2 array, 8-bit elements.
// Includes a behavioural GEMM core (fixed latency, never stalls) and a
// scoreboard that predicts each result from the job weights the bench drove.
module tb_gemm_fwec_stream_scheduler;

  localparam int SA  = 2;
  localparam int W   = 8;
  localparam int VW  = SA * W;
  localparam int LAT = 2 * SA;
  localparam int OD  = 16;
  localparam int CW  = 16;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start;
  logic [CW-1:0] num_vectors;
  logic          w_valid, w_ready;
  logic [VW-1:0] w_row;
  logic          act_valid, act_ready;
  logic [VW-1:0] act_data;
  logic          sa_w_we;
  logic          sa_w_idx;
  logic [VW-1:0] sa_w_row, sa_act, sa_out;
  logic          res_valid, res_ready, res_last;
  logic [VW-1:0] res_data;
  logic          busy, done;
  logic [1:0]    dbg_state;

  gemm_fwec_stream_scheduler #(
    .SA_SIZE(SA), .WEIGHT_ACTIVATION_SIZE(W), .OUT_DEPTH(OD), .CNT_W(CW)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .num_vectors(num_vectors),
    .w_valid(w_valid), .w_ready(w_ready), .w_row(w_row),
    .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
    .sa_w_we(sa_w_we), .sa_w_idx(sa_w_idx), .sa_w_row(sa_w_row),
    .sa_act(sa_act), .sa_out(sa_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_last(res_last), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int acc_seen = 0;
  int res_idx = 0;
  int job_num = 0;
  int rr_mode = 0;          // 0: res_ready high, 1: random, 2: held low
  bit res_rose = 1'b0;
  logic [VW-1:0] job_r0, job_r1;
  logic [VW-1:0] last_res;
  logic [VW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // out[k] = sum_j act[j] * row_j[k], modulo 2^W
  function automatic logic [VW-1:0] gemm2(input logic [VW-1:0] r0, input logic [VW-1:0] r1,
                                          input logic [VW-1:0] a);
    logic [W-1:0] o0, o1;
    o0 = a[7:0] * r0[7:0]  + a[15:8] * r1[7:0];
    o1 = a[7:0] * r0[15:8] + a[15:8] * r1[15:8];
    return {o1, o0};
  endfunction

  // ---------------- behavioural core ----------------
  logic [VW-1:0] core_rows [SA];
  logic [VW-1:0] core_eff  [SA];
  logic [VW-1:0] core_pipe [LAT];
  assign sa_out = core_pipe[LAT-1];

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < LAT; i++) core_pipe[i] <= '0;
    end else begin
      core_eff = core_rows;
      if (sa_w_we) core_eff[sa_w_idx] = sa_w_row;
      core_rows    <= core_eff;
      core_pipe[0] <= gemm2(core_eff[0], core_eff[1], sa_act);
      for (int i = 1; i < LAT; i++) core_pipe[i] <= core_pipe[i-1];
    end
  end

  // ---------------- res_ready driver ----------------
  always @(posedge clk) begin
    #1;
    case (rr_mode)
      0:       res_ready = 1'b1;
      1:       res_ready = 1'($urandom_range(0, 1));
      default: res_ready = 1'b0;
    endcase
  end

  // ---------------- scoreboard (samples mid-cycle) ----------------
  always @(negedge clk) begin
    if (!resetn) begin
      exp_q.delete();
    end else begin
      if (act_valid && act_ready) begin
        exp_q.push_back(gemm2(job_r0, job_r1, act_data));
        acc_seen++;
      end
      if (res_valid) res_rose = 1'b1;
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          check("res_unexpected", 32'(res_data), 32'hDEAD);
        end else begin
          check("res_data", 32'(res_data), 32'(exp_q.pop_front()));
        end
        check("res_last", 32'(res_last), 32'(res_idx == job_num - 1));
        last_res = res_data;
        res_idx++;
      end
      if (done) done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(input int num);
    job_num  = num;
    res_idx  = 0;
    res_rose = 1'b0;
    start = 1'b1;
    num_vectors = CW'(num);
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
  endtask

  task automatic send_row(input logic [VW-1:0] row);
    int k;
    k = 0;
    w_valid = 1'b1;
    w_row = row;
    forever begin
      @(negedge clk);
      if (w_ready) break;
      k++;
      if (k > 300) begin
        check("w_ready_timeout", 32'(k), 32'd0);
        break;
      end
    end
    @(posedge clk); #1;
    w_valid = 1'b0;
  endtask

  task automatic send_act(input logic [VW-1:0] data, output int waited);
    waited = 0;
    act_valid = 1'b1;
    act_data = data;
    forever begin
      @(negedge clk);
      if (act_ready) break;
      waited++;
      if (waited > 300) begin
        check("act_ready_timeout", 32'(waited), 32'd0);
        break;
      end
    end
    @(posedge clk); #1;
    act_valid = 1'b0;
  endtask

  task automatic wait_done();
    int k, d0;
    k = 0;
    d0 = done_cnt;
    while (done_cnt == d0 && k < 600) begin
      @(posedge clk); #1;
      k++;
    end
    check("done_seen", 32'(done_cnt - d0), 32'd1);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("res_count", 32'(res_idx), 32'(job_num));
  endtask

  // ---------------- test ----------------
  typedef struct {
    logic [VW-1:0] r0;
    logic [VW-1:0] r1;
    logic [VW-1:0] act;
    logic [VW-1:0] exp;
  } vec_t;

  vec_t vt[4];

  initial begin
    int wt, k, acc0, d0;
    logic [VW-1:0] held;

    vt[0] = '{16'h0003, 16'h0200, 16'h0502, 16'h0A06};  // {3,0},{0,2} x {2,5} = {6,10}
    vt[1] = '{16'h0003, 16'h0200, 16'h0203, 16'h0409};  // x {3,2} = {9,4}
    vt[2] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0202};  // 2*255*255 mod 256 = 2
    vt[3] = '{16'h0201, 16'h0403, 16'h0605, 16'h2217};  // {1,2},{3,4} x {5,6} = {23,34}

    resetn = 1'b0; start = 1'b0; num_vectors = '0;
    w_valid = 1'b0; w_row = '0; act_valid = 1'b0; act_data = '0;
    job_r0 = '0; job_r1 = '0; last_res = '0;
    for (int i = 0; i < SA; i++) core_rows[i] = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_w_ready", 32'(w_ready), 32'd0);
    check("rst_act_ready", 32'(act_ready), 32'd0);
    check("rst_sa_w_we", 32'(sa_w_we), 32'd0);
    check("rst_sa_act", 32'(sa_act), 32'd0);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;

    // table-driven single-vector jobs, with result latency check
    for (int i = 0; i < 4; i++) begin
      job_r0 = vt[i].r0;
      job_r1 = vt[i].r1;
      do_start(1);
      send_row(vt[i].r0);
      send_row(vt[i].r1);
      send_act(vt[i].act, wt);
      k = 0;
      while (!res_valid && k < 40) begin
        @(negedge clk);
        k++;
      end
      check("res_latency", 32'(k), 32'(LAT + 1));
      wait_done();
      check("vec_res", 32'(last_res), 32'(vt[i].exp));
    end

    // back-to-back acts: act_ready must never drop
    job_r0 = vt[0].r0; job_r1 = vt[0].r1;
    do_start(2);
    send_row(job_r0);
    send_row(job_r1);
    send_act(vt[0].act, wt);
    check("b2b_wait0", 32'(wt), 32'd0);
    send_act(vt[1].act, wt);
    check("b2b_wait1", 32'(wt), 32'd0);
    wait_done();
    check("b2b_last", 32'(last_res), 32'(vt[1].exp));

    // num_vectors = 0: weights load, done, no results
    do_start(0);
    send_row(16'h1111);
    send_row(16'h2222);
    wait_done();
    repeat (5) @(posedge clk);
    #1;
    check("nv0_res_valid", 32'(res_rose), 32'd0);

    // credit limit: results held back, only OUT_DEPTH vectors admitted
    job_r0 = 16'($urandom); job_r1 = 16'($urandom);
    rr_mode = 2;
    @(posedge clk); #1;
    do_start(40);
    send_row(job_r0);
    send_row(job_r1);
    acc0 = acc_seen;
    for (int i = 0; i < 40; i++) begin
      if (i == OD) begin
        held = 16'($urandom);
        act_valid = 1'b1;
        act_data = held;
        repeat (40) @(negedge clk);
        check("credit_accepted", 32'(acc_seen - acc0), 32'(OD));
        check("credit_act_ready", 32'(act_ready), 32'd0);
        rr_mode = 0;
        send_act(held, wt);
      end else begin
        send_act(16'($urandom), wt);
      end
    end
    wait_done();

    // reset mid-stream with three results in flight
    job_r0 = vt[3].r0; job_r1 = vt[3].r1;
    do_start(5);
    send_row(job_r0);
    send_row(job_r1);
    for (int i = 0; i < 3; i++) send_act(16'($urandom), wt);
    d0 = done_cnt;
    resetn = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_res_valid", 32'(res_valid), 32'd0);
    check("abort_act_ready", 32'(act_ready), 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_no_res", 32'(res_valid), 32'd0);

    // next job after abort, then randomized jobs against the model
    for (int j = 0; j < 7; j++) begin
      int n;
      job_r0 = (j == 0) ? vt[3].r0 : 16'($urandom);
      job_r1 = (j == 0) ? vt[3].r1 : 16'($urandom);
      n = (j == 0) ? 3 : $urandom_range(1, 30);
      rr_mode = (j == 0) ? 0 : 1;
      do_start(n);
      send_row(job_r0);
      send_row(job_r1);
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
        send_act(16'($urandom), wt);
      end
      wait_done();
      rr_mode = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // hard time limit
  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "time limit");
  end

endmodule
